// File: rtl/riscv_lsu.sv
// Load-store unit: sequences one core memory access over a ready/rvalid data port.
// Latency: 2 cycles minimum (issue+accept, response, DONE); stall held until DONE.
// Backpressure: holds req/addr/be/wd while mem_ready_i is low; watchdog aborts stuck accesses.
module riscv_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        lsu_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic        mem_ready_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rd_i
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int unsigned   CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rd_q, rd_d;
    logic          err_q, err_d;

    logic [1:0]  off;
    logic        bad, tmo, mem_req;
    logic [3:0]  be;
    logic [31:0] wd, lane, ld_data;

    assign off = core_addr_i[1:0];
    assign tmo = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        case (core_size_i)
            3'd0, 3'd4: bad = 1'b0;
            3'd1, 3'd5: bad = off[0];
            3'd2:       bad = |off;
            default:    bad = 1'b1;
        endcase
    end

    always_comb begin
        be = 4'b1111;
        wd = core_wd_i;
        case (core_size_i[1:0])
            2'd0: begin
                be = 4'b0001 << off;
                wd = {4{core_wd_i[7:0]}};
            end
            2'd1: begin
                be = off[1] ? 4'b1100 : 4'b0011;
                wd = {2{core_wd_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign lane = mem_rd_i >> {off, 3'b000};

    always_comb begin
        case (core_size_i)
            3'd0:    ld_data = {{24{lane[7]}}, lane[7:0]};
            3'd1:    ld_data = {{16{lane[15]}}, lane[15:0]};
            3'd4:    ld_data = {24'b0, lane[7:0]};
            3'd5:    ld_data = {16'b0, lane[15:0]};
            default: ld_data = mem_rd_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        err_d   = err_q;
        mem_req = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (core_req_i) begin
                    if (bad) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                        rd_d    = '0;
                    end else begin
                        mem_req = 1'b1;
                        state_d = mem_ready_i ? S_WAIT : S_REQ;
                    end
                end
            end
            S_REQ: begin
                mem_req = 1'b1;
                cnt_d   = cnt_q + CW'(1);
                if (mem_ready_i) begin
                    state_d = S_WAIT;
                end else if (tmo) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    rd_d    = '0;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (mem_rvalid_i) begin
                    state_d = S_DONE;
                    err_d   = 1'b0;
                    rd_d    = core_we_i ? 32'h0 : ld_data;
                end else if (tmo) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    rd_d    = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    // Bus fields are zeroed whenever no request is outstanding so the port is quiet.
    assign mem_req_o    = mem_req;
    assign mem_we_o     = mem_req & core_we_i;
    assign mem_be_o     = mem_req ? be : 4'b0000;
    assign mem_addr_o   = mem_req ? {core_addr_i[31:2], 2'b00} : 32'h0;
    assign mem_wd_o     = mem_req ? wd : 32'h0;
    assign core_stall_o = core_req_i & (state_q != S_DONE);
    assign lsu_err_o    = err_q & (state_q == S_DONE);
    assign core_rd_o    = rd_q;
endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: directed corner cases plus randomized accesses against a
// transaction-level reference model (lane math, extension rules, watchdog timing).
module tb_riscv_lsu;
    localparam int TMO   = 8;
    localparam int NEVER = 99;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        core_req_i, core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i, core_wd_i, core_rd_o;
    logic        core_stall_o, lsu_err_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wd_o;
    logic        mem_ready_i, mem_rvalid_i;
    logic [31:0] mem_rd_i;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] last_rd = 32'h0;

    riscv_lsu #(.TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
        .core_addr_i(core_addr_i), .core_wd_i(core_wd_i), .core_rd_o(core_rd_o),
        .core_stall_o(core_stall_o), .lsu_err_o(lsu_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
        .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i), .mem_rd_i(mem_rd_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic ref_bad(input logic [2:0] sz, input logic [31:0] a);
        int unsigned s = sz;
        int unsigned o = a % 4;
        if (s == 3 || s >= 6) return 1'b1;
        if (s % 4 == 1 && o % 2 == 1) return 1'b1;
        if (s == 2 && o != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] sz, input logic [31:0] a);
        int unsigned o = a % 4;
        int unsigned s = sz % 4;
        if (s == 0) return 4'((32'd1 << o));
        if (s == 1) return (o >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] ref_wd(input logic [2:0] sz, input logic [31:0] d);
        int unsigned s = sz % 4;
        if (s == 0) return (d % 256) * 32'h0101_0101;
        if (s == 1) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] sz, input logic [31:0] a,
                                             input logic [31:0] word);
        logic [31:0] v;
        v = word >> (8 * (a % 4));
        case (sz)
            3'd0: begin v = v % 256;   if (v >= 128)   v = v - 32'd256;   end
            3'd4: v = v % 256;
            3'd1: begin v = v % 65536; if (v >= 32768) v = v - 32'd65536; end
            3'd5: v = v % 65536;
            default: ;
        endcase
        return v;
    endfunction

    // rdly: cycle (from issue) memory accepts, NEVER = never; rvdly: cycles after accept, 0 = no response
    task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] word,
                          input int rdly, input int rvdly);
        logic bad, tmo;
        int done_cyc, c;
        bad = ref_bad(sz, a);
        tmo = 1'b0;
        c   = rdly + rvdly;
        if (bad) done_cyc = 1;
        else if (rdly == NEVER || rvdly == 0 || c > TMO) begin
            tmo = 1'b1;
            done_cyc = TMO + 1;
        end else done_cyc = c + 1;
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = sz;
        core_addr_i = a;
        core_wd_i   = d;
        mem_rd_i    = word;
        for (int k = 0; k <= done_cyc; k++) begin
            logic in_req;
            mem_ready_i  = !bad && (k == rdly) && (k < done_cyc);
            mem_rvalid_i = !bad && rvdly != 0 && rdly != NEVER && (k == c) && (k < done_cyc);
            in_req = !bad && (k <= rdly) && (k < done_cyc);
            @(negedge clk_i);
            check_eq("stall", core_stall_o, k < done_cyc);
            check_eq("mem_req", mem_req_o, in_req);
            if (in_req) begin
                check_eq("mem_addr", mem_addr_o, a & 32'hFFFF_FFFC);
                check_eq("mem_be", mem_be_o, ref_be(sz, a));
                check_eq("mem_wd", mem_wd_o, ref_wd(sz, d));
                check_eq("mem_we", mem_we_o, we);
            end
            if (k == done_cyc) begin
                last_rd = (bad || tmo || we) ? 32'h0 : ref_load(sz, a, word);
                check_eq("err_done", lsu_err_o, bad || tmo);
                check_eq("rd_done", core_rd_o, last_rd);
            end
            @(posedge clk_i);
            #1;
        end
        core_req_i   = 1'b0;
        mem_ready_i  = 1'b0;
        mem_rvalid_i = 1'b0;
        @(negedge clk_i);
        check_eq("idle_stall", core_stall_o, 1'b0);
        check_eq("idle_err", lsu_err_o, 1'b0);
        check_eq("idle_req", mem_req_o, 1'b0);
        check_eq("idle_rd", core_rd_o, last_rd);
        @(posedge clk_i);
        #1;
    endtask

    task automatic late_rvalid();
        mem_rvalid_i = 1'b1;
        mem_rd_i     = $urandom;
        @(negedge clk_i);
        check_eq("late_stall", core_stall_o, 1'b0);
        @(posedge clk_i);
        #1;
        mem_rvalid_i = 1'b0;
        @(negedge clk_i);
        check_eq("late_rd", core_rd_o, last_rd);
        check_eq("late_err", lsu_err_o, 1'b0);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        core_req_i = 1'b0; core_we_i = 1'b0; core_size_i = 3'd0;
        core_addr_i = 32'h0; core_wd_i = 32'h0;
        mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rd_i = 32'h0;
        repeat (2) @(negedge clk_i);
        check_eq("rst_stall", core_stall_o, 1'b0);
        check_eq("rst_err", lsu_err_o, 1'b0);
        check_eq("rst_rd", core_rd_o, 32'h0);
        check_eq("rst_req", mem_req_o, 1'b0);
        check_eq("rst_we", mem_we_o, 1'b0);
        check_eq("rst_be", mem_be_o, 4'h0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        access(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1);
        late_rvalid();
        access(1'b0, 3'd0, 32'h103, 32'h0, 32'h8011_2233, 0, 1);
        access(1'b0, 3'd4, 32'h103, 32'h0, 32'h8011_2233, 0, 1);
        access(1'b0, 3'd5, 32'h102, 32'h0, 32'h8011_2233, 0, 1);
        access(1'b0, 3'd1, 32'h102, 32'h0, 32'h8011_2233, 1, 2);
        access(1'b1, 3'd0, 32'h101, 32'h0000_00A5, 32'h0, 0, 1);
        access(1'b1, 3'd1, 32'h102, 32'h0000_BEEF, 32'h0, 0, 1);
        access(1'b0, 3'd2, 32'h102, 32'h0, 32'h1234_5678, 0, 1);
        access(1'b1, 3'd3, 32'h100, 32'h1, 32'h0, 0, 1);
        access(1'b0, 3'd2, 32'h200, 32'h0, 32'hCAFE_F00D, 3, 1);
        access(1'b0, 3'd2, 32'h204, 32'h0, 32'h0BAD_F00D, 0, TMO);
        access(1'b0, 3'd2, 32'h208, 32'h0, 32'h1111_2222, 0, TMO + 1);
        access(1'b1, 3'd2, 32'h20C, 32'h5, 32'h0, NEVER, 1);
        access(1'b0, 3'd2, 32'h210, 32'h0, 32'h3333_4444, 2, 0);

        // reset asserted while the access waits for its response
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2;
        core_addr_i = 32'h300; mem_ready_i = 1'b1;
        @(posedge clk_i);
        #1 mem_ready_i = 1'b0;
        @(negedge clk_i);
        check_eq("wait_stall", core_stall_o, 1'b1);
        #2 rst_ni = 1'b0;
        core_req_i = 1'b0;
        #1;
        check_eq("arst_stall", core_stall_o, 1'b0);
        check_eq("arst_req", mem_req_o, 1'b0);
        check_eq("arst_err", lsu_err_o, 1'b0);
        check_eq("arst_rd", core_rd_o, 32'h0);
        last_rd = 32'h0;
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        late_rvalid();

        for (int i = 0; i < 250; i++) begin
            logic [2:0] sz;
            int rd, rv;
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            rd = ($urandom_range(0, 15) == 0) ? NEVER : $urandom_range(0, 5);
            rv = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
            access(1'($urandom), sz, $urandom, $urandom, $urandom, rd, rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
